// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light phase arbiter: light encodings,
// the phase state enum and small helpers for durations, round-robin order
// and light decoding.
package tl_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Request indices used by the round-robin pointer and pending vector.
    localparam logic [1:0] IDX_NS  = 2'd0;
    localparam logic [1:0] IDX_EW  = 2'd1;
    localparam logic [1:0] IDX_PED = 2'd2;

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5,
        EMG       = 3'd6
    } state_t;

    // Timer load value: a zero configuration still gives a one-cycle phase.
    function automatic logic [3:0] phase_load(input logic [3:0] cfg);
        phase_load = (cfg == 4'd0) ? 4'd0 : (cfg - 4'd1);
    endfunction

    // Index served after the given one (NS -> EW -> PED -> NS).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        rr_next = (idx == IDX_PED) ? IDX_NS : (idx + 2'd1);
    endfunction

    // First pending index at or after the pointer, in cyclic order.
    function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] ptr);
        logic [1:0] first;
        logic [1:0] second;
        first  = ptr;
        second = rr_next(ptr);
        if (pend[first]) begin
            rr_pick = first;
        end else if (pend[second]) begin
            rr_pick = second;
        end else begin
            rr_pick = rr_next(second);
        end
    endfunction

    // Lights for a state: {light_NS, light_EW, pedestrian_signal}.
    // dir selects the green direction while in EMG (0 = NS, 1 = EW).
    function automatic logic [6:0] decode_lights(input state_t st, input logic dir);
        case (st)
            NS_GREEN:  decode_lights = {GREEN,  RED,    1'b0};
            NS_YELLOW: decode_lights = {YELLOW, RED,    1'b0};
            EW_GREEN:  decode_lights = {RED,    GREEN,  1'b0};
            EW_YELLOW: decode_lights = {RED,    YELLOW, 1'b0};
            PED_WALK:  decode_lights = {RED,    RED,    1'b1};
            EMG:       decode_lights = dir ? {RED, GREEN, 1'b0} : {GREEN, RED, 1'b0};
            default:   decode_lights = {RED,    RED,    1'b0};
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Four-bit phase down-timer. A load sets the count; otherwise it counts
// down and holds at zero, where expired stays high.
module phase_timer (
    input  logic       clk,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] value,
    output logic       expired
);

    // Count register: load wins, otherwise decrement until zero.
    always_ff @(posedge clk) begin
        if (load) begin
            value <= load_value;
        end else if (value != 4'd0) begin
            value <= value - 4'd1;
        end else begin
            value <= value;
        end
    end

    assign expired = (value == 4'd0);

endmodule

// File: rtl/phase_arbiter.sv
// Traffic-light phase arbiter: sequences NS / EW / pedestrian phases with
// round-robin service of pending requests and emergency preemption.
// Outputs are registered copies of the decode of the next state, so they
// always match the registered phase.
module phase_arbiter
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cfg_green,
    input  logic [3:0] cfg_yellow,
    input  logic [3:0] cfg_clear,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       req_ped,
    input  logic       emergency,
    input  logic       emg_dir,
    output logic [2:0] light_NS,
    output logic [2:0] light_EW,
    output logic       pedestrian_signal,
    output logic       ack_ns,
    output logic       ack_ew,
    output logic       ack_ped
);

    state_t     state_r;
    state_t     next_s;
    logic [2:0] pend_r;       // {ped, ew, ns}
    logic [1:0] ptr_r;        // next index to consider first
    logic       emg_dir_r;    // direction latched on EMG entry
    logic       dir_next_s;
    logic [1:0] pick_s;
    state_t     pick_state_s;
    logic       load_s;
    logic [3:0] load_value_s;
    logic [3:0] timer_value;
    logic       expired;
    logic [2:0] req_s;
    logic [2:0] serve_s;

    assign req_s = {req_ped, req_ew, req_ns};

    phase_timer u_timer (
        .clk        (clk),
        .load       (load_s),
        .load_value (load_value_s),
        .value      (timer_value),
        .expired    (expired)
    );

    // Round-robin choice among pending requests.
    always_comb begin
        pick_s = rr_pick(pend_r, ptr_r);
        case (pick_s)
            IDX_EW:  pick_state_s = EW_GREEN;
            IDX_PED: pick_state_s = PED_WALK;
            default: pick_state_s = NS_GREEN;
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ALL_RED: begin
                if (!expired) begin
                    next_s = ALL_RED;
                end else if (emergency) begin
                    next_s = EMG;
                end else if (pend_r != 3'b000) begin
                    next_s = pick_state_s;
                end else begin
                    next_s = ALL_RED;
                end
            end
            NS_GREEN: begin
                if (emergency) begin
                    next_s = emg_dir ? NS_YELLOW : EMG;
                end else if (expired && (pend_r[IDX_EW] || pend_r[IDX_PED])) begin
                    next_s = NS_YELLOW;
                end else begin
                    next_s = NS_GREEN;
                end
            end
            EW_GREEN: begin
                if (emergency) begin
                    next_s = emg_dir ? EMG : EW_YELLOW;
                end else if (expired && (pend_r[IDX_NS] || pend_r[IDX_PED])) begin
                    next_s = EW_YELLOW;
                end else begin
                    next_s = EW_GREEN;
                end
            end
            NS_YELLOW: next_s = expired ? ALL_RED : NS_YELLOW;
            EW_YELLOW: next_s = expired ? ALL_RED : EW_YELLOW;
            PED_WALK:  next_s = (expired || emergency) ? ALL_RED : PED_WALK;
            EMG: begin
                if (emergency) begin
                    next_s = EMG;
                end else begin
                    next_s = emg_dir_r ? EW_YELLOW : NS_YELLOW;
                end
            end
            default: next_s = ALL_RED;
        endcase
    end

    // Timer load on every state change (and on reset) with the new phase length.
    always_comb begin
        load_s = rst || (next_s != state_r);
        if (rst) begin
            load_value_s = phase_load(cfg_clear);
        end else begin
            case (next_s)
                NS_GREEN, EW_GREEN, PED_WALK: load_value_s = phase_load(cfg_green);
                NS_YELLOW, EW_YELLOW:         load_value_s = phase_load(cfg_yellow);
                ALL_RED:                      load_value_s = phase_load(cfg_clear);
                default:                      load_value_s = 4'd0;
            endcase
        end
    end

    // Which requests are being served this cycle: the phase is current or
    // being entered; EMG serves only its (latched or latching) direction.
    always_comb begin
        dir_next_s = (state_r == EMG) ? emg_dir_r : emg_dir;
        serve_s[IDX_NS]  = (state_r == NS_GREEN) || (next_s == NS_GREEN) ||
                           ((state_r == EMG) && !emg_dir_r) ||
                           ((next_s == EMG) && !dir_next_s);
        serve_s[IDX_EW]  = (state_r == EW_GREEN) || (next_s == EW_GREEN) ||
                           ((state_r == EMG) && emg_dir_r) ||
                           ((next_s == EMG) && dir_next_s);
        serve_s[IDX_PED] = (state_r == PED_WALK) || (next_s == PED_WALK);
    end

    // State, pending bits, pointer, emergency latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= ALL_RED;
            pend_r            <= 3'b000;
            ptr_r             <= IDX_NS;
            emg_dir_r         <= 1'b0;
            light_NS          <= RED;
            light_EW          <= RED;
            pedestrian_signal <= 1'b0;
            ack_ns            <= 1'b0;
            ack_ew            <= 1'b0;
            ack_ped           <= 1'b0;
        end else begin
            state_r <= next_s;
            pend_r  <= (pend_r | req_s) & ~serve_s;
            ack_ns  <= serve_s[IDX_NS]  && (pend_r[IDX_NS]  || req_ns);
            ack_ew  <= serve_s[IDX_EW]  && (pend_r[IDX_EW]  || req_ew);
            ack_ped <= serve_s[IDX_PED] && (pend_r[IDX_PED] || req_ped);
            if ((state_r == ALL_RED) && (next_s != ALL_RED) && (next_s != EMG)) begin
                ptr_r <= rr_next(pick_s);
            end else begin
                ptr_r <= ptr_r;
            end
            if ((next_s == EMG) && (state_r != EMG)) begin
                emg_dir_r <= emg_dir;
            end else begin
                emg_dir_r <= emg_dir_r;
            end
            {light_NS, light_EW, pedestrian_signal} <= decode_lights(next_s, dir_next_s);
        end
    end

endmodule

// File: tb/tb_phase_arbiter.sv
// Scenario bench for phase_arbiter. Each scenario is a per-cycle table of
// {stimulus, expected outputs}; the expected entry is pushed to the
// scoreboard when its stimulus is driven and popped after the clock edge.
module tb_phase_arbiter;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    // stimulus bits: {rst, req_ns, req_ew, req_ped, emergency, emg_dir}
    localparam logic [5:0] S0    = 6'b000000;
    localparam logic [5:0] SRST  = 6'b100000;
    localparam logic [5:0] SNS   = 6'b010000;
    localparam logic [5:0] SEW   = 6'b001000;
    localparam logic [5:0] SPED  = 6'b000100;
    localparam logic [5:0] SALL  = 6'b011100;
    localparam logic [5:0] SEM1  = 6'b000011;
    localparam logic [5:0] SEM0  = 6'b000010;

    logic       clk = 1'b0;
    logic       rst, req_ns, req_ew, req_ped, emergency, emg_dir;
    logic [3:0] cfg_green, cfg_yellow, cfg_clear;
    logic [2:0] light_NS, light_EW;
    logic       pedestrian_signal, ack_ns, ack_ew, ack_ped;

    logic [15:0] plan_q[$];   // {stimulus, expected}
    logic [9:0]  exp_q[$];    // {light_NS, light_EW, ped, ack_ns, ack_ew, ack_ped}
    int vectors = 0;
    int errors  = 0;

    phase_arbiter dut (
        .clk(clk), .rst(rst),
        .cfg_green(cfg_green), .cfg_yellow(cfg_yellow), .cfg_clear(cfg_clear),
        .req_ns(req_ns), .req_ew(req_ew), .req_ped(req_ped),
        .emergency(emergency), .emg_dir(emg_dir),
        .light_NS(light_NS), .light_EW(light_EW),
        .pedestrian_signal(pedestrian_signal),
        .ack_ns(ack_ns), .ack_ew(ack_ew), .ack_ped(ack_ped)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ev(input logic [2:0] ns, input logic [2:0] ew,
                                      input logic ped, input logic [2:0] acks);
        ev = {ns, ew, ped, acks};
    endfunction

    task automatic add(input logic [5:0] s, input logic [9:0] e, input int n);
        for (int i = 0; i < n; i++) plan_q.push_back({s, e});
    endtask

    task automatic test_reset();
        logic [15:0] p; logic [9:0] e, obs; int cyc;
        add(SRST, ev(R, R, 1'b0, 3'b000), 2);
        add(S0,   ev(R, R, 1'b0, 3'b000), 20);
        cyc = 0;
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            {rst, req_ns, req_ew, req_ped, emergency, emg_dir} = p[15:10];
            exp_q.push_back(p[9:0]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {light_NS, light_EW, pedestrian_signal, ack_ns, ack_ew, ack_ped};
            vectors++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset cyc %0d got %b want %b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_service();
        logic [15:0] p; logic [9:0] e, obs; int cyc;
        // NS pulse while idle, then rest on green
        add(SNS,  ev(R, R, 1'b0, 3'b000), 1);
        add(S0,   ev(G, R, 1'b0, 3'b100), 1);
        add(S0,   ev(G, R, 1'b0, 3'b000), 8);
        // one-cycle emergency toward EW pushes NS into yellow; all three requested
        add(SEM1, ev(Y, R, 1'b0, 3'b000), 1);
        add(SALL, ev(Y, R, 1'b0, 3'b000), 1);
        add(S0,   ev(R, R, 1'b0, 3'b000), 2);
        // round robin after NS: EW, PED, NS
        add(S0,   ev(R, G, 1'b0, 3'b010), 1);
        add(S0,   ev(R, G, 1'b0, 3'b000), 3);
        add(S0,   ev(R, Y, 1'b0, 3'b000), 2);
        add(S0,   ev(R, R, 1'b0, 3'b000), 2);
        add(S0,   ev(R, R, 1'b1, 3'b001), 1);
        add(S0,   ev(R, R, 1'b1, 3'b000), 3);
        add(S0,   ev(R, R, 1'b0, 3'b000), 2);
        add(S0,   ev(G, R, 1'b0, 3'b100), 1);
        add(S0,   ev(G, R, 1'b0, 3'b000), 3);
        // own request during green: immediate ack, no re-service
        add(SNS,  ev(G, R, 1'b0, 3'b100), 1);
        add(S0,   ev(G, R, 1'b0, 3'b000), 1);
        // EW request during NS rest
        add(SEW,  ev(G, R, 1'b0, 3'b000), 1);
        add(S0,   ev(Y, R, 1'b0, 3'b000), 2);
        add(S0,   ev(R, R, 1'b0, 3'b000), 2);
        add(S0,   ev(R, G, 1'b0, 3'b010), 1);
        add(S0,   ev(R, G, 1'b0, 3'b000), 4);
        cyc = 0;
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            {rst, req_ns, req_ew, req_ped, emergency, emg_dir} = p[15:10];
            exp_q.push_back(p[9:0]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {light_NS, light_EW, pedestrian_signal, ack_ns, ack_ew, ack_ped};
            vectors++;
            if (obs !== e) begin
                errors++;
                $display("FAIL service cyc %0d got %b want %b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_emergency();
        logic [15:0] p; logic [9:0] e, obs; int cyc;
        add(SNS,  ev(R, G, 1'b0, 3'b000), 1);
        add(S0,   ev(R, Y, 1'b0, 3'b000), 2);
        add(S0,   ev(R, R, 1'b0, 3'b000), 2);
        add(S0,   ev(G, R, 1'b0, 3'b100), 1);
        add(S0,   ev(G, R, 1'b0, 3'b000), 1);
        // emergency toward EW at NS green cycle 2: full yellow, clearance, EMG
        add(SEM1, ev(Y, R, 1'b0, 3'b000), 2);
        add(SEM1, ev(R, R, 1'b0, 3'b000), 2);
        add(SEM1, ev(R, G, 1'b0, 3'b000), 2);
        // direction change ignored; ped stays pending; EW request acked by EMG
        add(SEM0, ev(R, G, 1'b0, 3'b000), 1);
        add(SEM0 | SPED, ev(R, G, 1'b0, 3'b000), 1);
        add(SEM0 | SEW,  ev(R, G, 1'b0, 3'b010), 1);
        add(SEM0, ev(R, G, 1'b0, 3'b000), 1);
        // release: EW yellow, clearance, retained ped served
        add(S0,   ev(R, Y, 1'b0, 3'b000), 2);
        add(S0,   ev(R, R, 1'b0, 3'b000), 2);
        add(S0,   ev(R, R, 1'b1, 3'b001), 1);
        add(S0,   ev(R, R, 1'b1, 3'b000), 3);
        add(S0,   ev(R, R, 1'b0, 3'b000), 5);
        cyc = 0;
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            {rst, req_ns, req_ew, req_ped, emergency, emg_dir} = p[15:10];
            exp_q.push_back(p[9:0]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {light_NS, light_EW, pedestrian_signal, ack_ns, ack_ew, ack_ped};
            vectors++;
            if (obs !== e) begin
                errors++;
                $display("FAIL emergency cyc %0d got %b want %b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_ped_emergency();
        logic [15:0] p; logic [9:0] e, obs; int cyc;
        add(SPED, ev(R, R, 1'b0, 3'b000), 1);
        add(S0,   ev(R, R, 1'b1, 3'b001), 1);
        add(S0,   ev(R, R, 1'b1, 3'b000), 1);
        // walk aborted, clearance, EMG toward NS
        add(SEM0, ev(R, R, 1'b0, 3'b000), 2);
        add(SEM0, ev(G, R, 1'b0, 3'b000), 2);
        // reset mid-EMG: straight to all-red, no yellow, walk not restored
        add(SRST | SEM0, ev(R, R, 1'b0, 3'b000), 1);
        add(S0,   ev(R, R, 1'b0, 3'b000), 6);
        cyc = 0;
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            {rst, req_ns, req_ew, req_ped, emergency, emg_dir} = p[15:10];
            exp_q.push_back(p[9:0]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            obs = {light_NS, light_EW, pedestrian_signal, ack_ns, ack_ew, ack_ped};
            vectors++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ped_emergency cyc %0d got %b want %b", cyc, obs, e);
            end
            cyc++;
        end
    endtask

    initial begin
        cfg_green  = 4'd4;
        cfg_yellow = 4'd2;
        cfg_clear  = 4'd2;
        {rst, req_ns, req_ew, req_ped, emergency, emg_dir} = 6'b100000;
        test_reset();
        test_service();
        test_emergency();
        test_ped_emergency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/phase_arbiter.md
PHASE_ARBITER -- requirements
Module: phase_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports SHALL be named clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 cfg_green  in  4  green/walk duration in cycles (0 treated as 1).
REQ-005 cfg_yellow  in  4  yellow duration in cycles (0 treated as 1).
REQ-006 cfg_clear  in  4  all-red clearance duration in cycles (0 treated as 1).
REQ-007 req_ns, req_ew, req_ped  in  1 each  service requests, pulse or level.
REQ-008 emergency  in  1  level; preemption active while high.
REQ-009 emg_dir  in  1  emergency direction: 0=NS, 1=EW.
REQ-010 light_NS, light_EW  out  3 each  encoding: RED=100, YELLOW=010, GREEN=001.
REQ-011 pedestrian_signal  out  1  walk indication.
REQ-012 ack_ns, ack_ew, ack_ped  out  1 each  one-cycle pulse when the matching pending request is served.

Function
REQ-013 States SHALL be ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK, EMG; outputs SHALL be decoded from the registered state only (Moore).
REQ-014 Each request SHALL set a pending bit on any cycle it is high; the bit SHALL clear, with its ack pulse, on the cycle the state enters the matching NS_GREEN/EW_GREEN/PED_WALK.
REQ-015 A request asserted while its own phase is green/walk SHALL be cleared immediately, with ack, without re-service.
REQ-016 A 4-bit down-timer SHALL load max(cfg,1)-1 on state entry, sampling cfg only then; the state SHALL last exactly max(cfg,1) cycles before expiry.
REQ-017 ALL_RED on expiry: emergency high -> EMG; else round-robin among pending NS->EW->PED, starting after the last served; none pending -> stay ALL_RED (idle, timer held at 0).
REQ-018 NS_GREEN/EW_GREEN on expiry: any other bit pending -> own YELLOW; else remain green (rest) until another request arrives, then YELLOW next cycle.
REQ-019 YELLOW on expiry -> ALL_RED; PED_WALK on expiry -> ALL_RED.
REQ-020 Lights: xx_GREEN -> that direction 001, other 100; xx_YELLOW -> 010/100; ALL_RED and PED_WALK -> both 100; pedestrian_signal=1 only in PED_WALK.
REQ-021 Emergency rising while green in emg_dir -> EMG next cycle, no light change; green in other direction -> that YELLOW immediately (full yellow), ALL_RED, EMG; PED_WALK -> ALL_RED next cycle (walk aborted, pending ped not restored); YELLOW/ALL_RED -> complete, then EMG.
REQ-022 emg_dir SHALL be latched on EMG entry; changes during EMG SHALL be ignored; EMG drives latched direction GREEN, other RED, pedestrian_signal 0.
REQ-023 EMG on emergency low -> YELLOW of latched direction, then normal sequencing; pending bits SHALL be retained through EMG; EMG serves and acks the pending bit of its direction.
REQ-024 Round-robin pointer SHALL update only on normal (non-EMG) service.

Reset
REQ-025 rst SHALL dominate all inputs: next cycle state=ALL_RED, timer=max(cfg_clear,1)-1, pending=0, pointer=NS (NS first), light_NS=light_EW=100, pedestrian_signal=0, acks=0.
REQ-026 rst asserted mid-phase (including EMG) SHALL abort the phase with no yellow.

Structure
REQ-027 Package tl_pkg SHALL hold light encodings RED/YELLOW/GREEN and the state enum; the block SHALL import it.
REQ-028 The down-counter SHALL be a sub-module phase_timer (load, value, expired); everything else in phase_arbiter.

Verification (cfg_green=4, cfg_yellow=2, cfg_clear=2 unless stated)
REQ-029 rst high 2 cycles, then released, no requests -> lights 100/100, ped 0, stays ALL_RED 20 cycles.
REQ-030 req_ns one-cycle pulse while idle -> ack_ns pulse, light_NS=001 held; no other requests -> rests green indefinitely.
REQ-031 req_ew during NS rest -> NS 010 for exactly 2 cycles, 100/100 for 2, EW 001 with ack_ew.
REQ-032 req_ns, req_ew, req_ped together after NS last served -> service order EW, PED (ped=1 for 4 cycles), NS.
REQ-033 emergency=1, emg_dir=1 at NS green cycle 2 -> NS yellow 2, clear 2, EW 001 held while high; drop -> EW 010 2 cycles.
REQ-034 emergency during PED_WALK -> ped 0 next cycle, clear 2, EMG; rst mid-EMG -> 100/100 next cycle.
